lbdr_flit_injector: RTL

- Network-interface packetizer at the local input of a router: turns packet requests plus a payload stream into header/body/tail flits.
- Presents them through the same FIFO-read interface the LBDR routing unit consumes: empty, flit_id, dst_addr, plus flit data.
- It is the writer/source side of the flit stream that LBDR reads. It drives LBDR directly in unit benches and the local port FIFO in the mesh.

---
 rtl/lbdr_flit_injector.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lbdr_flit_injector.sv
// Local-port packetizer: turns packet requests plus a payload stream into
// header/body/tail flits behind a one-flit FIFO-style read interface.
module lbdr_flit_injector #(
    parameter int         DATA_W   = 32,
    parameter logic [3:0] CUR_ADDR = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [3:0]        pkt_dst,
    input  logic [3:0]        pkt_len,
    input  logic              pay_valid,
    output logic              pay_ready,
    input  logic [DATA_W-1:0] pay_data,
    input  logic              rd_en,
    output logic              empty,
    output logic [2:0]        flit_id,
    output logic [3:0]        dst_addr,
    output logic [DATA_W-1:0] flit_data,
    output logic              pkt_err,
    output logic [7:0]        pkt_count
);

    typedef enum logic [1:0] {IDLE, BODY, TAIL} state_t;

    localparam logic [2:0] ID_HEAD = 3'b001;
    localparam logic [2:0] ID_BODY = 3'b010;
    localparam logic [2:0] ID_TAIL = 3'b100;

    state_t             state_reg;
    logic [3:0]         rem_reg;
    logic [3:0]         dst_reg;
    logic               empty_reg;
    logic [2:0]         flit_id_reg;
    logic [3:0]         dst_addr_reg;
    logic [DATA_W-1:0]  flit_data_reg;
    logic               pkt_err_reg;
    logic [7:0]         pkt_count_reg;

    logic               slot_free;
    logic               pop;
    logic               pkt_acc;
    logic               pay_acc;
    logic [3:0]         hdr_rem;
    logic [DATA_W-1:0]  hdr_data;

    // The holding register can take a new flit whenever it is empty or being popped.
    assign slot_free = empty_reg || rd_en;
    assign pop       = rd_en && !empty_reg;
    assign pkt_ready = (state_reg == IDLE) && slot_free;
    assign pay_ready = (state_reg != IDLE) && slot_free;
    assign pkt_acc   = pkt_valid && pkt_ready;
    assign pay_acc   = pay_valid && pay_ready;
    assign hdr_rem   = pkt_len - 4'd2;

    always_comb begin
        hdr_data      = '0;
        hdr_data[7:4] = CUR_ADDR;
        hdr_data[3:0] = pkt_dst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rem_reg       <= 4'd0;
            dst_reg       <= 4'd0;
            empty_reg     <= 1'b1;
            flit_id_reg   <= 3'b000;
            dst_addr_reg  <= 4'd0;
            flit_data_reg <= '0;
            pkt_err_reg   <= 1'b0;
            pkt_count_reg <= 8'd0;
        end else begin
            pkt_err_reg <= 1'b0;

            if (pop && flit_id_reg == ID_TAIL)
                pkt_count_reg <= pkt_count_reg + 8'd1;

            // A pop empties the slot unless a load below refills it this cycle.
            if (pop) begin
                empty_reg   <= 1'b1;
                flit_id_reg <= 3'b000;
            end

            case (state_reg)
                IDLE: begin
                    if (pkt_acc) begin
                        if (pkt_len >= 4'd2) begin
                            empty_reg     <= 1'b0;
                            flit_id_reg   <= ID_HEAD;
                            dst_addr_reg  <= pkt_dst;
                            flit_data_reg <= hdr_data;
                            dst_reg       <= pkt_dst;
                            rem_reg       <= hdr_rem;
                            state_reg     <= (hdr_rem != 4'd0) ? BODY : TAIL;
                        end else begin
                            pkt_err_reg <= 1'b1;
                        end
                    end
                end
                BODY: begin
                    if (pay_acc) begin
                        empty_reg     <= 1'b0;
                        flit_id_reg   <= ID_BODY;
                        dst_addr_reg  <= dst_reg;
                        flit_data_reg <= pay_data;
                        rem_reg       <= rem_reg - 4'd1;
                        if (rem_reg == 4'd1)
                            state_reg <= TAIL;
                    end
                end
                TAIL: begin
                    if (pay_acc) begin
                        empty_reg     <= 1'b0;
                        flit_id_reg   <= ID_TAIL;
                        dst_addr_reg  <= dst_reg;
                        flit_data_reg <= pay_data;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign empty     = empty_reg;
    assign flit_id   = flit_id_reg;
    assign dst_addr  = dst_addr_reg;
    assign flit_data = flit_data_reg;
    assign pkt_err   = pkt_err_reg;
    assign pkt_count = pkt_count_reg;

endmodule
